ps2_rx: RTL
===========

# ps2_rx

PS/2 serial frame receiver and scan-code prefix tracker. It sits directly upstream of the PS/2 keyboard decoder (the `ps2` stage that drives ZX matrix, joystick and magic/reset/pause keys). It receives the raw `ps2_clk`/`ps2_dat` pins and delivers one scan code per key event, with extended (E0) and release (F0) flags attached. The block is receive-only and never drives the PS/2 lines.

## Interface

Parameters:
- CLK_FREQ, 28_000_000: clk28 frequency in Hz.
- FILTER_LEN, 8: clk28 cycles the synchronised PS/2 clock must hold a new level before the filtered clock accepts it.
- TIMEOUT_US, 200: maximum gap between bit strobes inside a frame, in µs. TIMEOUT_CYC = CLK_FREQ/1_000_000*TIMEOUT_US, which is 5600 at the defaults.

Ports:
- clk28  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk28.
- ps2_clk_in  in  1  raw PS/2 clock, asynchronous.
- ps2_dat_in  in  1  raw PS/2 data, asynchronous.
- code  out  8  last delivered scan code.
- code_ext  out  1  an E0 prefix preceded `code`.
- code_rel  out  1  an F0 prefix preceded `code`.
- code_valid  out  1  one-cycle strobe: code, code_ext and code_rel are new.
- frame_err  out  1  one-cycle strobe: the frame was dropped (parity, stop bit or timeout).
- busy  out  1  the frame FSM is not in IDLE.

## Operation

- **Input conditioning.** Each pin passes through a 2-FF synchroniser.
  - The filtered clock `fclk` resets to 1.
  - A counter runs while the synchronised clock differs from `fclk` and clears whenever they are equal.
  - When the counter reaches FILTER_LEN, `fclk` takes the new level.
  - A bit strobe is the cycle in which `fclk` goes 1→0. The synchronised data bit is sampled in that same cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on a strobe with data=0 (start bit), go to DATA with bit_cnt=0. A strobe with data=1 is ignored: the state stays IDLE and no error is raised.
  - DATA: shift the bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: on the strobe, go to IDLE in all cases.
    - If stop=1 and parity passes, the frame is done.
    - Otherwise pulse frame_err.
    - Parity passes when the data bits plus the parity bit contain an odd number of ones.
- **Timeout.** A counter clears on every strobe and counts while the FSM is outside IDLE. When it reaches TIMEOUT_CYC:
  - the FSM goes to IDLE and frame_err pulses;
  - any partial byte is discarded;
  - the ext and rel prefix flags are cleared.
- **Prefix tracking**, applied to each completed byte:
  - E0: set ext_pend. No code_valid.
  - F0: set rel_pend. No code_valid.
  - Any other byte (including E1, AA, FA, FE): load `code`, set code_ext=ext_pend and code_rel=rel_pend, pulse code_valid, then clear both pending flags.
  - frame_err also clears both pending flags.
- **Held outputs.** `code`, `code_ext` and `code_rel` hold their values until the next delivery.

## Timing

- **Reset values.** code=0x00, code_ext=0, code_rel=0, code_valid=0, frame_err=0, busy=0. Also fclk=1, FSM in IDLE, pending flags cleared, all counters 0.
- **Reset mid-frame.** The partial frame is discarded. No strobes are produced during the reset cycle or the cycle after it.
- **Edge latency.** A raw clock edge appears on `fclk` 2+FILTER_LEN cycles later, counting from the first clk28 edge that sees the new level.
- **Delivery latency.**
  - Let N be the strobe cycle of the stop bit. code_valid or frame_err is high in cycle N+1 only.
  - Timeout: frame_err is high in the cycle after the counter reaches TIMEOUT_CYC.
- **Exclusivity.** code_valid and frame_err are never high together. busy deasserts in cycle N+1.
- **Glitches.** A clock pulse shorter than FILTER_LEN cycles produces no strobe.
- **Frame back-to-back with timeout.** If a start-bit strobe lands in the same cycle as the timeout, the strobe wins: the counter clears and the frame continues.

## Configuration

- PS2_RX_PARITY_EN, defined: parity failure drops the frame and pulses frame_err.
- PS2_RX_PARITY_EN, undefined: the parity bit is sampled but ignored. Only the stop bit and the timeout can cause frame_err.

## Test plan

- **Make code.** Frame 0x1C, parity 0, stop 1, bit period 80 µs → one code_valid, code=0x1C, ext=0, rel=0. busy is high from the start strobe until N+1.
- **Extended release.** Frames F0, 1C, then E0, F0, 75 → exactly two code_valid: first (0x1C, rel=1, ext=0), then (0x75, ext=1, rel=1). No strobe is produced for any prefix byte.
- **Parity error** (with PS2_RX_PARITY_EN). 0x1C with parity 1 → frame_err pulses once and there is no code_valid. Without the macro → code_valid with code=0x1C.
- **Timeout recovery.** Send F0, then the start bit plus 3 data bits, then silence:
  - frame_err pulses 5600 cycles after the last strobe and busy drops;
  - a following 0x1C frame delivers rel=0, showing the pending flag was cleared.
- **Glitch immunity.** Inject 4-cycle low pulses on ps2_clk_in while idle and mid-frame → no strobes, and frame 0x5A still decodes correctly.
- **Reset mid-frame.** Assert rst_n=0 for one cycle after the 4th data bit:
  - all outputs return to their reset values;
  - the remaining bits of the interrupted frame are treated as idle noise or as a new start, per the FSM rules;
  - the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver pin and scan-code bundle: master is the receiver, slave is the pin driver / code consumer.
interface ps2_rx_if;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic [7:0] code;
  logic       code_ext;
  logic       code_rel;
  logic       code_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ps2_clk_in, ps2_dat_in,
    output code, code_ext, code_rel, code_valid, frame_err, busy
  );

  modport slave (
    output ps2_clk_in, ps2_dat_in,
    input  code, code_ext, code_rel, code_valid, frame_err, busy
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver with E0/F0 prefix tracking; receive-only.
// Optional macro PS2_RX_PARITY_EN: when defined, a parity failure drops the frame.
module ps2_rx #(
  parameter int unsigned CLK_FREQ   = 28_000_000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic     clk28,
  input  logic     rst_n,
  ps2_rx_if.master ps2_bus
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned FILT_W      = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BIT_W       = 3;
  localparam logic [7:0]  PFX_EXT     = 8'hE0;
  localparam logic [7:0]  PFX_REL     = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // synchronisers and clock filter
  logic              r_clk_meta, r_clk_sync;
  logic              r_dat_meta, r_dat_sync;
  logic              r_fclk, r_fclk_d;
  logic [FILT_W-1:0] r_filt_cnt;

  // frame state
  state_t            r_state;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [7:0]        r_shift;
`ifdef PS2_RX_PARITY_EN
  logic              r_par;
`endif
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_ext_pend, r_rel_pend;

  // registered outputs
  logic [7:0]        r_code;
  logic              r_code_ext, r_code_rel;
  logic              r_code_valid, r_frame_err, r_busy;

  // next-state values
  logic              w_fclk_nxt;
  logic [FILT_W-1:0] w_filt_cnt_nxt;
  state_t            w_state_nxt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [7:0]        w_shift_nxt;
`ifdef PS2_RX_PARITY_EN
  logic              w_par_nxt;
`endif
  logic [TO_W-1:0]   w_to_cnt_nxt;
  logic              w_ext_pend_nxt, w_rel_pend_nxt;
  logic [7:0]        w_code_nxt;
  logic              w_code_ext_nxt, w_code_rel_nxt;
  logic              w_code_valid_nxt, w_frame_err_nxt;
  logic              w_strobe, w_timeout, w_frame_ok;

  assign w_strobe  = r_fclk_d & ~r_fclk;
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC));

  // fclk follows the synchronised clock only after FILTER_LEN stable cycles
  always_comb begin
    w_fclk_nxt     = r_fclk;
    w_filt_cnt_nxt = '0;
    if (r_clk_sync != r_fclk) begin
      if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        w_fclk_nxt = r_clk_sync;
      end else begin
        w_filt_cnt_nxt = r_filt_cnt + FILT_W'(1);
      end
    end
  end

  // frame FSM, timeout and prefix tracking
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
`ifdef PS2_RX_PARITY_EN
    w_par_nxt        = r_par;
`endif
    w_to_cnt_nxt     = '0;
    w_ext_pend_nxt   = r_ext_pend;
    w_rel_pend_nxt   = r_rel_pend;
    w_code_nxt       = r_code;
    w_code_ext_nxt   = r_code_ext;
    w_code_rel_nxt   = r_code_rel;
    w_code_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_frame_ok       = 1'b0;

    if (!w_strobe && r_state != S_IDLE) begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
    end

    if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_sync) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt   = {r_dat_sync, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == BIT_W'(7)) begin
            w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
`ifdef PS2_RX_PARITY_EN
          w_par_nxt   = r_dat_sync;
`endif
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
`ifdef PS2_RX_PARITY_EN
          w_frame_ok  = r_dat_sync & (^{r_shift, r_par});
`else
          w_frame_ok  = r_dat_sync;
`endif
          if (!w_frame_ok) begin
            w_frame_err_nxt = 1'b1;
            w_ext_pend_nxt  = 1'b0;
            w_rel_pend_nxt  = 1'b0;
          end else if (r_shift == PFX_EXT) begin
            w_ext_pend_nxt  = 1'b1;
          end else if (r_shift == PFX_REL) begin
            w_rel_pend_nxt  = 1'b1;
          end else begin
            w_code_nxt       = r_shift;
            w_code_ext_nxt   = r_ext_pend;
            w_code_rel_nxt   = r_rel_pend;
            w_code_valid_nxt = 1'b1;
            w_ext_pend_nxt   = 1'b0;
            w_rel_pend_nxt   = 1'b0;
          end
        end
      endcase
    end else if (w_timeout) begin
      // a strobe in the same cycle takes priority over the timeout
      w_state_nxt     = S_IDLE;
      w_shift_nxt     = '0;
      w_to_cnt_nxt    = '0;
      w_frame_err_nxt = 1'b1;
      w_ext_pend_nxt  = 1'b0;
      w_rel_pend_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_clk_meta   <= 1'b1;
      r_clk_sync   <= 1'b1;
      r_dat_meta   <= 1'b1;
      r_dat_sync   <= 1'b1;
      r_fclk       <= 1'b1;
      r_fclk_d     <= 1'b1;
      r_filt_cnt   <= '0;
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
`ifdef PS2_RX_PARITY_EN
      r_par        <= 1'b0;
`endif
      r_to_cnt     <= '0;
      r_ext_pend   <= 1'b0;
      r_rel_pend   <= 1'b0;
      r_code       <= '0;
      r_code_ext   <= 1'b0;
      r_code_rel   <= 1'b0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_clk_meta   <= ps2_bus.ps2_clk_in;
      r_clk_sync   <= r_clk_meta;
      r_dat_meta   <= ps2_bus.ps2_dat_in;
      r_dat_sync   <= r_dat_meta;
      r_fclk       <= w_fclk_nxt;
      r_fclk_d     <= r_fclk;
      r_filt_cnt   <= w_filt_cnt_nxt;
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
`ifdef PS2_RX_PARITY_EN
      r_par        <= w_par_nxt;
`endif
      r_to_cnt     <= w_to_cnt_nxt;
      r_ext_pend   <= w_ext_pend_nxt;
      r_rel_pend   <= w_rel_pend_nxt;
      r_code       <= w_code_nxt;
      r_code_ext   <= w_code_ext_nxt;
      r_code_rel   <= w_code_rel_nxt;
      r_code_valid <= w_code_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign ps2_bus.code       = r_code;
  assign ps2_bus.code_ext   = r_code_ext;
  assign ps2_bus.code_rel   = r_code_rel;
  assign ps2_bus.code_valid = r_code_valid;
  assign ps2_bus.frame_err  = r_frame_err;
  assign ps2_bus.busy       = r_busy;

endmodule
